// File: rtl/state_machine_if.sv
// Control/datapath signal bundle between the accumulator-processor control unit
// and its datapath: run controls and status in, one-hot selects and strobes out.
interface state_machine_if;
    logic        enable;
    logic        z;
    logic [31:0] IR;
    logic        pc_inc;
    logic        finish;
    logic        data_ram_we;
    logic        inst_ram_we;
    logic [7:0]  alu_sel;
    logic [7:0]  bus_sel;
    logic [8:0]  reg_sel;

    modport master (
        output enable, z, IR,
        input  pc_inc, finish, data_ram_we, inst_ram_we, alu_sel, bus_sel, reg_sel
    );

    modport slave (
        input  enable, z, IR,
        output pc_inc, finish, data_ram_we, inst_ram_we, alu_sel, bus_sel, reg_sel
    );
endinterface

// File: rtl/state_machine.sv
// Multi-cycle control unit: fetch, decode IR[7:0], one micro-step per clock,
// Moore outputs held in registers loaded from the decode of the next state.
module state_machine (
    input  logic              clk,
    input  logic              reset,
    state_machine_if.slave    bus
);

    typedef enum logic [4:0] {
        S_IDLE   = 5'd0,
        S_FETCH1 = 5'd1,
        S_FETCH2 = 5'd2,
        S_DECODE = 5'd3,
        S_LOAD1  = 5'd4,
        S_LOAD2  = 5'd5,
        S_STORE  = 5'd6,
        S_MOVR   = 5'd7,
        S_MOVAC  = 5'd8,
        S_ADD    = 5'd9,
        S_SUB    = 5'd10,
        S_MUL    = 5'd11,
        S_INC    = 5'd12,
        S_DEC    = 5'd13,
        S_JUMP   = 5'd14,
        S_LDAR   = 5'd15,
        S_SHL    = 5'd16,
        S_SHR    = 5'd17,
        S_DONE   = 5'd18
    } state_t;

    typedef struct packed {
        logic       pc_inc;
        logic       finish;
        logic       data_ram_we;
        logic [7:0] alu_sel;
        logic [7:0] bus_sel;
        logic [8:0] reg_sel;
    } ctrl_t;

    state_t state_r;
    state_t state_next_s;
    ctrl_t  ctrl_r;
    logic   unused_ir_s;

    assign unused_ir_s = ^bus.IR[31:8];

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH1: begin c.reg_sel = 9'h040; c.pc_inc = 1'b1; end
            S_LOAD2:  begin c.bus_sel = 8'h80; c.reg_sel = 9'h020; end
            S_STORE:  begin c.bus_sel = 8'h20; c.data_ram_we = 1'b1; end
            S_MOVR:   begin c.bus_sel = 8'h20; c.reg_sel = 9'h010; end
            S_MOVAC:  begin c.bus_sel = 8'h10; c.reg_sel = 9'h020; end
            S_ADD:    begin c.bus_sel = 8'h10; c.alu_sel = 8'h02; c.reg_sel = 9'h080; end
            S_SUB:    begin c.bus_sel = 8'h10; c.alu_sel = 8'h04; c.reg_sel = 9'h080; end
            S_MUL:    begin c.bus_sel = 8'h10; c.alu_sel = 8'h08; c.reg_sel = 9'h080; end
            S_INC:    begin c.alu_sel = 8'h10; c.reg_sel = 9'h080; end
            S_DEC:    begin c.alu_sel = 8'h20; c.reg_sel = 9'h080; end
            S_JUMP:   begin c.bus_sel = 8'h40; c.reg_sel = 9'h001; end
            S_LDAR:   begin c.bus_sel = 8'h20; c.reg_sel = 9'h002; end
            S_SHL:    begin c.alu_sel = 8'h40; c.reg_sel = 9'h080; end
            S_SHR:    begin c.alu_sel = 8'h80; c.reg_sel = 9'h080; end
            S_DONE:   begin c.finish = 1'b1; end
            default:  begin c = '0; end
        endcase
        return c;
    endfunction

    // Next-state logic; DONE is sticky regardless of enable.
    always_comb begin
        state_next_s = state_r;
        if (state_r == S_DONE) begin
            state_next_s = S_DONE;
        end else if (bus.enable) begin
            case (state_r)
                S_IDLE:   state_next_s = S_FETCH1;
                S_FETCH1: state_next_s = S_FETCH2;
                S_FETCH2: state_next_s = S_DECODE;
                S_DECODE: begin
                    case (bus.IR[7:0])
                        8'd1:    state_next_s = S_LOAD1;
                        8'd2:    state_next_s = S_STORE;
                        8'd3:    state_next_s = S_MOVR;
                        8'd4:    state_next_s = S_MOVAC;
                        8'd5:    state_next_s = S_ADD;
                        8'd6:    state_next_s = S_SUB;
                        8'd7:    state_next_s = S_MUL;
                        8'd8:    state_next_s = S_INC;
                        8'd9:    state_next_s = S_DEC;
                        8'd10:   state_next_s = bus.z ? S_JUMP : S_FETCH1;
                        8'd11:   state_next_s = S_JUMP;
                        8'd12:   state_next_s = S_LDAR;
                        8'd13:   state_next_s = S_SHL;
                        8'd14:   state_next_s = S_SHR;
                        8'd15:   state_next_s = S_DONE;
                        default: state_next_s = S_FETCH1;
                    endcase
                end
                S_LOAD1:  state_next_s = S_LOAD2;
                default:  state_next_s = S_FETCH1;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State register with outputs registered from the decode of the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            ctrl_r  <= '0;
        end else begin
            state_r <= state_next_s;
            ctrl_r  <= decode_ctrl(state_next_s);
        end
    end

    assign bus.pc_inc      = ctrl_r.pc_inc;
    assign bus.finish      = ctrl_r.finish;
    assign bus.data_ram_we = ctrl_r.data_ram_we;
    assign bus.inst_ram_we = 1'b0;
    assign bus.alu_sel     = ctrl_r.alu_sel;
    assign bus.bus_sel     = ctrl_r.bus_sel;
    assign bus.reg_sel     = ctrl_r.reg_sel;

endmodule

// File: tb/tb_state_machine.sv
// Random program runner for state_machine: a per-instruction micro-step table
// feeds an expected-output queue that a separate monitor drains and checks.
module tb_state_machine;

    typedef logic [28:0] vec_t;  // {pc_inc, finish, dwe, iwe, alu[7:0], bus[7:0], reg[8:0]}

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    state_machine_if bus ();

    state_machine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    vec_t exp_q[$];
    vec_t last_out;
    int   total = 0;
    int   bad   = 0;
    int   step_no = 0;

    function automatic vec_t mk(input logic pc, input logic fin, input logic dwe,
                                input logic [7:0] alu, input logic [7:0] bsel,
                                input logic [8:0] rs);
        return {pc, fin, dwe, 1'b0, alu, bsel, rs};
    endfunction

    function automatic vec_t actual();
        return {bus.pc_inc, bus.finish, bus.data_ram_we, bus.inst_ram_we,
                bus.alu_sel, bus.bus_sel, bus.reg_sel};
    endfunction

    // Monitor: one expected vector per clock edge while the queue holds entries.
    initial begin
        vec_t e;
        vec_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = actual();
                total++;
                step_no++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL step%0d got=%h expected=%h", step_no, a, e);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        vec_t a;
        a = actual();
        total++;
        if (a !== 29'd0) begin
            bad++;
            $display("FAIL %s got=%h expected=0", name, a);
        end
    endtask

    // One micro-step: random stalls repeat the held outputs until the step is taken.
    task automatic step(input vec_t v);
        bit taken;
        taken = 1'b0;
        while (!taken) begin
            @(negedge clk);
            if ($urandom_range(0, 3) != 0) begin
                bus.enable = 1'b1;
                exp_q.push_back(v);
                last_out = v;
                taken = 1'b1;
            end else begin
                bus.enable = 1'b0;
                exp_q.push_back(last_out);
            end
        end
    endtask

    task automatic run_instr(input logic [7:0] op, input logic zv);
        vec_t steps[$];
        logic [31:0] r;
        steps.delete();
        case (op)
            8'd1: begin steps.push_back(29'd0); steps.push_back(mk(0, 0, 0, 8'h00, 8'h80, 9'h020)); end
            8'd2:  steps.push_back(mk(0, 0, 1, 8'h00, 8'h20, 9'h000));
            8'd3:  steps.push_back(mk(0, 0, 0, 8'h00, 8'h20, 9'h010));
            8'd4:  steps.push_back(mk(0, 0, 0, 8'h00, 8'h10, 9'h020));
            8'd5:  steps.push_back(mk(0, 0, 0, 8'h02, 8'h10, 9'h080));
            8'd6:  steps.push_back(mk(0, 0, 0, 8'h04, 8'h10, 9'h080));
            8'd7:  steps.push_back(mk(0, 0, 0, 8'h08, 8'h10, 9'h080));
            8'd8:  steps.push_back(mk(0, 0, 0, 8'h10, 8'h00, 9'h080));
            8'd9:  steps.push_back(mk(0, 0, 0, 8'h20, 8'h00, 9'h080));
            8'd10: if (zv) steps.push_back(mk(0, 0, 0, 8'h00, 8'h40, 9'h001));
            8'd11: steps.push_back(mk(0, 0, 0, 8'h00, 8'h40, 9'h001));
            8'd12: steps.push_back(mk(0, 0, 0, 8'h00, 8'h20, 9'h002));
            8'd13: steps.push_back(mk(0, 0, 0, 8'h40, 8'h00, 9'h080));
            8'd14: steps.push_back(mk(0, 0, 0, 8'h80, 8'h00, 9'h080));
            8'd15: steps.push_back(mk(0, 1, 0, 8'h00, 8'h00, 9'h000));
            default: ;
        endcase
        step(mk(1, 0, 0, 8'h00, 8'h00, 9'h040));
        // Change IR only once FETCH1 is entered, so the previous decode is undisturbed.
        @(posedge clk);
        #1;
        r = $urandom;
        bus.IR = {r[31:8], op};
        bus.z  = zv;
        step(29'd0);
        step(29'd0);
        foreach (steps[i]) step(steps[i]);
    endtask

    task automatic pulse_reset(input string name);
        @(posedge clk);
        #3;
        bus.enable = 1'b0;
        reset = 1'b0;
        #1;
        check_zero(name);
        @(negedge clk);
        check_zero({name, "_held"});
        reset = 1'b1;
        last_out = 29'd0;
    endtask

    initial begin
        logic [7:0] op;
        int r;
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.z = 1'b0;
        bus.IR = 32'd0;
        last_out = 29'd0;
        #1;
        reset = 1'b0;
        #1;
        check_zero("reset_async");
        @(negedge clk);
        check_zero("reset_held");
        reset = 1'b1;

        for (int p = 0; p < 5; p++) begin
            run_instr(8'd8, 1'b0);
            run_instr(8'd10, 1'b0);
            run_instr(8'd10, 1'b1);
            for (int k = 0; k < 40; k++) begin
                r = $urandom_range(0, 15);
                if (r == 15) op = 8'($urandom_range(16, 255));
                else op = 8'(r);
                run_instr(op, 1'($urandom_range(0, 1)));
            end
            run_instr(8'd15, 1'($urandom_range(0, 1)));
            for (int c = 0; c < 22; c++) begin
                @(negedge clk);
                bus.enable = 1'($urandom_range(0, 1));
                exp_q.push_back(mk(0, 1, 0, 8'h00, 8'h00, 9'h000));
            end
            pulse_reset("reset_in_done");
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/state_machine.md
Name: state_machine

Overview:
Multi-cycle control unit of the accumulator processor. It fetches each instruction from instruction RAM into IR and decodes the opcode in IR[7:0]. It then drives one-hot bus-source, register-load and ALU-operation selects plus memory write enables for the datapath, one micro-step per clock. It runs until an END instruction, then asserts finish.

Parameters:
none (opcode and select encodings fixed below)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  run enable; 0 freezes FSM
z  input  1  ALU zero flag from datapath
IR  input  32  current instruction; opcode = IR[7:0]
pc_inc  output  1  PC increment strobe
finish  output  1  program completed
data_ram_we  output  1  data RAM write enable
inst_ram_we  output  1  instruction RAM write enable
alu_sel  output  8  one-hot ALU op: [0]PASS [1]ADD [2]SUB [3]MUL [4]INC [5]DEC [6]SHL [7]SHR
bus_sel  output  8  one-hot bus source: [0]PC [1]AR [2]DR [3]TR [4]R [5]AC [6]IR operand field [7]data RAM
reg_sel  output  9  one-hot load enable: [0]PC(from bus) [1]AR [2]DR [3]TR [4]R [5]AC(from bus) [6]IR(from instruction RAM) [7]AC(from ALU) [8]reserved, always 0

Behaviour:
- One clock; reset is asynchronous and active-low. reset=0 forces state IDLE immediately, regardless of clk.
- Moore outputs, decoded combinationally from the state register only. Every output not listed for a state is 0.
- inst_ram_we is always 0; it is reserved for the external program loader.
- In IDLE, and whenever reset=0, all outputs are 0.
- enable=0 at a clock edge holds the current state; outputs keep that state's values. enable=1 lets the FSM advance.
- IDLE -> FETCH1.
- FETCH1: reg_sel=9'h040, pc_inc=1. Next state FETCH2.
- FETCH2: no outputs (IR settles). Next state DECODE.
- DECODE: no outputs. Branches on IR[7:0] to the execute state.
- Opcode table, with execute-state outputs; each execute state returns to FETCH1:
  - 0 NOP: none.
  - 1 LOADAC: LOAD1 (none, RAM read latency), then LOAD2 (bus_sel=8'h80, reg_sel=9'h020).
  - 2 STOREAC: bus_sel=8'h20, data_ram_we=1.
  - 3 MOVR (R<=AC): bus_sel=8'h20, reg_sel=9'h010.
  - 4 MOVAC (AC<=R): bus_sel=8'h10, reg_sel=9'h020.
  - 5 ADD: bus_sel=8'h10, alu_sel=8'h02, reg_sel=9'h080.
  - 6 SUB: bus_sel=8'h10, alu_sel=8'h04, reg_sel=9'h080.
  - 7 MUL: bus_sel=8'h10, alu_sel=8'h08, reg_sel=9'h080.
  - 8 INC: alu_sel=8'h10, reg_sel=9'h080.
  - 9 DEC: alu_sel=8'h20, reg_sel=9'h080.
  - 10 JMPZ: z sampled in DECODE. If z=1, JUMP state (bus_sel=8'h40, reg_sel=9'h001). If z=0, go directly to FETCH1.
  - 11 JMP: JUMP state.
  - 12 LDAR (AR<=AC): bus_sel=8'h20, reg_sel=9'h002.
  - 13 SHL: alu_sel=8'h40, reg_sel=9'h080.
  - 14 SHR: alu_sel=8'h80, reg_sel=9'h080.
  - 15 END: go to DONE.
  - Any other opcode executes as NOP.
- DONE: finish=1. Held until reset; enable has no effect in DONE.
- Latency from FETCH1 to the next FETCH1: 4 cycles for single-step ops, 5 for LOADAC, 3 for NOP and for JMPZ not taken.
- At most one bit set in each of alu_sel, bus_sel and reg_sel in any state.

Test Plan:
- Reset: hold reset=0 -> all outputs 0 at once (asynchronous, without a clock edge); state IDLE.
- INC flow: release reset with enable=1, IR=32'd8 -> edge 1 pc_inc=1, reg_sel=9'h040; edges 2-3 all 0; edge 4 alu_sel=8'h10, reg_sel=9'h080; edge 5 back in FETCH1 (pc_inc=1).
- Stall: in FETCH2 drive enable=0 for 3 cycles -> state and outputs frozen; resumes at DECODE after enable=1.
- JMPZ: IR=10. With z=0 in DECODE, next state is FETCH1 with no JUMP cycle. With z=1, one cycle of bus_sel=8'h40 and reg_sel=9'h001.
- Memory ops: IR=1 -> LOAD1 all 0, then LOAD2 bus_sel=8'h80 and reg_sel=9'h020. IR=2 -> data_ram_we=1 and bus_sel=8'h20 for exactly 1 cycle.
- END: IR=15 -> finish=1 held for 20+ cycles with any enable. Asserting reset mid-DONE clears finish at once and returns to IDLE.
